// File: rtl/exec_stage.sv
// exec_stage: RV32I execute unit plus the EX/MEM pipeline register.
// Define RV32M_EN to add the multiplier and the iterative divider FSM.
module exec_stage #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            keep,
  input  logic            nop,
  input  logic [4:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] read_data2_pype1,
  input  logic [2:0]      writeback_control_pype1,
  input  logic [1:0]      MemRW_pype1,
  input  logic [XLEN-1:0] PCp4_pype1,
  input  logic [4:0]      WReg_pype1,
  input  logic [2:0]      funct3_pype1,
  input  logic [1:0]      dsize_pype1,
  input  logic [1:0]      forwarding_stall_load_pyc_pype1,
  output logic            ex_busy,
  output logic [XLEN-1:0] ALU_co_pype,
  output logic [2:0]      writeback_control_pype2,
  output logic [1:0]      MemRW_pype2,
  output logic [XLEN-1:0] PCp4_pype2,
  output logic [XLEN-1:0] read_data2_pype2,
  output logic [4:0]      WReg_pype2,
  output logic [2:0]      funct3_pype2,
  output logic [1:0]      dsize_pype2,
  output logic [1:0]      forwarding_stall_load_pyc_pype2
);

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] m_res;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] div_res;
  logic [4:0]      shamt;
  logic            is_m_op;
  logic            fsm_bubble;
  logic            fsm_done;

  // RV32I single-cycle ALU; unknown and M codes fall to zero here
  always_comb begin
    shamt    = op_b[4:0];
    base_res = '0;
    case (alu_op)
      OP_ADD:   base_res = op_a + op_b;
      OP_SUB:   base_res = op_a - op_b;
      OP_SLL:   base_res = op_a << shamt;
      OP_SLT:   base_res = {31'd0, $signed(op_a) < $signed(op_b)};
      OP_SLTU:  base_res = {31'd0, op_a < op_b};
      OP_XOR:   base_res = op_a ^ op_b;
      OP_SRL:   base_res = op_a >> shamt;
      OP_SRA:   base_res = $signed(op_a) >>> shamt;
      OP_OR:    base_res = op_a | op_b;
      OP_AND:   base_res = op_a & op_b;
      OP_PASSB: base_res = op_b;
      default:  base_res = '0;
    endcase
  end

`ifdef RV32M_EN
  typedef enum logic {S_IDLE, S_DIV} state_t;

  localparam logic [4:0] CNT_INIT = 5'(DIV_ITERS - 1);

  state_t          state_q, state_d;
  logic [4:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            isrem_q, isrem_d;

  logic            is_div, is_sdiv, is_rem;
  logic            div_zero, div_ovf, div_start;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [63:0]     ext_a, ext_b, prod;
  logic [XLEN:0]   shl, diff;
  logic [XLEN-1:0] rem_it, quo_it;

  // M decode, multiplier and single-cycle divide special cases
  always_comb begin
    is_div   = alu_op == OP_DIV || alu_op == OP_DIVU ||
               alu_op == OP_REM || alu_op == OP_REMU;
    is_sdiv  = alu_op == OP_DIV || alu_op == OP_REM;
    is_rem   = alu_op == OP_REM || alu_op == OP_REMU;
    div_zero = op_b == '0;
    div_ovf  = is_sdiv && op_a == 32'h8000_0000 && op_b == '1;
    a_neg    = is_sdiv & op_a[31];
    b_neg    = is_sdiv & op_b[31];
    abs_a    = a_neg ? 32'd0 - op_a : op_a;
    abs_b    = b_neg ? 32'd0 - op_b : op_b;
    ext_a    = {32'd0, op_a};
    ext_b    = {32'd0, op_b};
    if ((alu_op == OP_MULH || alu_op == OP_MULHSU) && op_a[31])
      ext_a = {32'hFFFF_FFFF, op_a};
    if (alu_op == OP_MULH && op_b[31])
      ext_b = {32'hFFFF_FFFF, op_b};
    prod  = ext_a * ext_b;
    m_res = '0;
    case (alu_op)
      OP_MUL:    m_res = prod[31:0];
      OP_MULH,
      OP_MULHSU,
      OP_MULHU:  m_res = prod[63:32];
      OP_DIV,
      OP_DIVU:   m_res = div_zero ? 32'hFFFF_FFFF :
                         div_ovf  ? 32'h8000_0000 : 32'd0;
      OP_REM,
      OP_REMU:   m_res = div_zero ? op_a : 32'd0;
      default:   m_res = '0;
    endcase
  end

  // One restoring step and sign fix-up of the final quotient/remainder
  always_comb begin
    shl     = {rem_q, quo_q[31]};
    diff    = shl - {1'b0, dvs_q};
    rem_it  = diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0];
    quo_it  = {quo_q[XLEN-2:0], ~diff[XLEN]};
    div_res = isrem_q ? (rneg_q ? 32'd0 - rem_it : rem_it)
                      : (qneg_q ? 32'd0 - quo_it : quo_it);
  end

  // Divider next-state and handshake outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    isrem_d   = isrem_q;
    div_start = state_q == S_IDLE && is_div && !div_zero && !div_ovf;
    unique case (state_q)
      S_IDLE: begin
        if (div_start) begin
          state_d = S_DIV;
          cnt_d   = CNT_INIT;
          quo_d   = abs_a;
          rem_d   = '0;
          dvs_d   = abs_b;
          qneg_d  = a_neg ^ b_neg;
          rneg_d  = a_neg;
          isrem_d = is_rem;
        end
      end
      S_DIV: begin
        quo_d = quo_it;
        rem_d = rem_it;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = S_IDLE;
          cnt_d   = 5'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    fsm_bubble = div_start || (state_q == S_DIV && cnt_q != 5'd0);
    fsm_done   = state_q == S_DIV && cnt_q == 5'd0;
    ex_busy    = fsm_bubble;
  end

  // Divider state; keep freezes it, nop abandons the divide
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      isrem_q <= 1'b0;
    end else if (!keep) begin
      if (nop) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        quo_q   <= quo_d;
        rem_q   <= rem_d;
        dvs_q   <= dvs_d;
        qneg_q  <= qneg_d;
        rneg_q  <= rneg_d;
        isrem_q <= isrem_d;
      end
    end
  end
`else
  assign m_res      = '0;
  assign div_res    = '0;
  assign fsm_bubble = 1'b0;
  assign fsm_done   = 1'b0;
  assign ex_busy    = 1'b0;
`endif

  // Route M codes to the M result, everything else to the base ALU
  always_comb begin
    is_m_op = alu_op >= OP_MUL && alu_op <= OP_REMU;
    alu_res = is_m_op ? m_res : base_res;
  end

  // EX/MEM register: hold on keep, bubble on nop or divide in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      ALU_co_pype                     <= '0;
      writeback_control_pype2         <= '0;
      MemRW_pype2                     <= '0;
      PCp4_pype2                      <= '0;
      read_data2_pype2                <= '0;
      WReg_pype2                      <= '0;
      funct3_pype2                    <= '0;
      dsize_pype2                     <= '0;
      forwarding_stall_load_pyc_pype2 <= '0;
    end else if (!keep) begin
      if (nop || fsm_bubble) begin
        ALU_co_pype                     <= '0;
        writeback_control_pype2         <= '0;
        MemRW_pype2                     <= '0;
        PCp4_pype2                      <= '0;
        read_data2_pype2                <= '0;
        WReg_pype2                      <= '0;
        funct3_pype2                    <= '0;
        dsize_pype2                     <= '0;
        forwarding_stall_load_pyc_pype2 <= '0;
      end else begin
        ALU_co_pype                     <= fsm_done ? div_res : alu_res;
        writeback_control_pype2         <= writeback_control_pype1;
        MemRW_pype2                     <= MemRW_pype1;
        PCp4_pype2                      <= PCp4_pype1;
        read_data2_pype2                <= read_data2_pype1;
        WReg_pype2                      <= WReg_pype1;
        funct3_pype2                    <= funct3_pype1;
        dsize_pype2                     <= dsize_pype1;
        forwarding_stall_load_pyc_pype2 <= forwarding_stall_load_pyc_pype1;
      end
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// tb_exec_stage: scoreboard bench for exec_stage.
// Results are tagged by PC+4; the monitor pops one entry per new tag.
module tb_exec_stage;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASSB  = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd11;
  localparam logic [4:0] OP_MULH   = 5'd12;
  localparam logic [4:0] OP_MULHSU = 5'd13;
  localparam logic [4:0] OP_MULHU  = 5'd14;
  localparam logic [4:0] OP_DIV    = 5'd15;
  localparam logic [4:0] OP_DIVU   = 5'd16;
  localparam logic [4:0] OP_REM    = 5'd17;
  localparam logic [4:0] OP_REMU   = 5'd18;

  logic        clk = 1'b0;
  logic        rst, keep, nop;
  logic [4:0]  alu_op;
  logic [31:0] op_a, op_b, read_data2_pype1, PCp4_pype1;
  logic [2:0]  writeback_control_pype1, funct3_pype1;
  logic [1:0]  MemRW_pype1, dsize_pype1, forwarding_stall_load_pyc_pype1;
  logic [4:0]  WReg_pype1;
  logic        ex_busy;
  logic [31:0] ALU_co_pype, PCp4_pype2, read_data2_pype2;
  logic [2:0]  writeback_control_pype2, funct3_pype2;
  logic [1:0]  MemRW_pype2, dsize_pype2, forwarding_stall_load_pyc_pype2;
  logic [4:0]  WReg_pype2;

  always #5 clk = ~clk;

  exec_stage dut (
    .clk(clk), .rst(rst), .keep(keep), .nop(nop),
    .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .read_data2_pype1(read_data2_pype1),
    .writeback_control_pype1(writeback_control_pype1),
    .MemRW_pype1(MemRW_pype1), .PCp4_pype1(PCp4_pype1),
    .WReg_pype1(WReg_pype1), .funct3_pype1(funct3_pype1),
    .dsize_pype1(dsize_pype1),
    .forwarding_stall_load_pyc_pype1(forwarding_stall_load_pyc_pype1),
    .ex_busy(ex_busy), .ALU_co_pype(ALU_co_pype),
    .writeback_control_pype2(writeback_control_pype2),
    .MemRW_pype2(MemRW_pype2), .PCp4_pype2(PCp4_pype2),
    .read_data2_pype2(read_data2_pype2), .WReg_pype2(WReg_pype2),
    .funct3_pype2(funct3_pype2), .dsize_pype2(dsize_pype2),
    .forwarding_stall_load_pyc_pype2(forwarding_stall_load_pyc_pype2)
  );

  typedef struct {
    string       name;
    logic [31:0] alu, pc, rd2;
    logic [2:0]  wb, f3;
    logic [1:0]  mrw, ds, fwd;
    logic [4:0]  wr;
  } exp_t;

  exp_t        sbq[$];
  exp_t        cur;
  int          checks = 0;
  int          errors = 0;
  int          n = 0;
  logic [31:0] last_tag = '0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst !== 1'b1 && PCp4_pype2 !== 32'd0 && PCp4_pype2 !== 32'bx &&
        PCp4_pype2 !== last_tag) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0h expected=none",
                 PCp4_pype2);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_alu"}, 128'(ALU_co_pype), 128'(e.alu));
        chk({e.name, "_pass"},
            {PCp4_pype2, read_data2_pype2, writeback_control_pype2,
             MemRW_pype2, WReg_pype2, funct3_pype2, dsize_pype2,
             forwarding_stall_load_pyc_pype2},
            {e.pc, e.rd2, e.wb, e.mrw, e.wr, e.f3, e.ds, e.fwd});
      end
    end
    last_tag = PCp4_pype2;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alu_op = OP_ADD; op_a = '0; op_b = '0;
    read_data2_pype1 = '0; writeback_control_pype1 = '0;
    MemRW_pype1 = '0; PCp4_pype1 = '0; WReg_pype1 = '0;
    funct3_pype1 = '0; dsize_pype1 = '0;
    forwarding_stall_load_pyc_pype1 = '0;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] mrw,
                       input logic [4:0] wr, input string nm);
    n++;
    cur.name = nm;
    cur.alu  = '0;
    cur.pc   = 32'h1000 + 32'(n) * 4;
    cur.rd2  = ~cur.pc;
    cur.wb   = 3'(n);
    cur.mrw  = mrw;
    cur.wr   = wr;
    cur.f3   = 3'(n + 1);
    cur.ds   = 2'(n);
    cur.fwd  = 2'(n + 2);
    alu_op = op; op_a = a; op_b = b;
    read_data2_pype1 = cur.rd2; writeback_control_pype1 = cur.wb;
    MemRW_pype1 = cur.mrw; PCp4_pype1 = cur.pc; WReg_pype1 = cur.wr;
    funct3_pype1 = cur.f3; dsize_pype1 = cur.ds;
    forwarding_stall_load_pyc_pype1 = cur.fwd;
    #1;
  endtask

  task automatic expect_res(input logic [31:0] r);
    cur.alu = r;
    sbq.push_back(cur);
  endtask

  task automatic one(input logic [4:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] r,
                     input string nm);
    drive(op, a, b, 2'b00, 5'd7, nm);
    expect_res(r);
    step();
  endtask

  task automatic chk_zero(input string nm);
    chk(nm,
        {ALU_co_pype, PCp4_pype2, read_data2_pype2,
         writeback_control_pype2, MemRW_pype2, WReg_pype2, funct3_pype2,
         dsize_pype2, forwarding_stall_load_pyc_pype2, ex_busy},
        128'd0);
  endtask

`ifdef RV32M_EN
  task automatic wait_div(input int keep_at, output int nb,
                          output int bub, output int frz);
    logic [64:0] snap;
    nb = 0; bub = 0; frz = 0;
    for (int i = 0; i < 40 && ex_busy; i++) begin
      if (nb == keep_at) begin
        snap = {ALU_co_pype, PCp4_pype2, ex_busy};
        keep = 1'b1;
        repeat (3) begin
          step();
          if ({ALU_co_pype, PCp4_pype2, ex_busy} !== snap) frz++;
        end
        keep = 1'b0;
      end
      nb++;
      step();
      if (ex_busy && (ALU_co_pype !== 0 || PCp4_pype2 !== 0)) bub++;
    end
  endtask

  task automatic div_run(input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] r,
                         input string nm, input int keep_at);
    int nb, bub, frz;
    drive(op, a, b, 2'b00, 5'd9, nm);
    expect_res(r);
    wait_div(keep_at, nb, bub, frz);
    chk({nm, "_busy_cycles"}, 128'(nb), 128'd32);
    chk({nm, "_bubbles"}, 128'(bub), 128'd0);
    if (keep_at >= 0) chk({nm, "_keep_frozen"}, 128'(frz), 128'd0);
    step();
  endtask
`endif

  task automatic spec_one(input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] r,
                          input string nm);
    drive(op, a, b, 2'b00, 5'd5, nm);
    chk({nm, "_no_busy"}, 128'(ex_busy), 128'd0);
    expect_res(r);
    step();
  endtask

  initial begin
    logic [31:0] prev_pc;
    rst = 1'b1; keep = 1'b0; nop = 1'b0;
    idle_in();
    repeat (2) step();
    chk_zero("reset");
    rst = 1'b0;

    drive(OP_ADD, 32'd7, 32'd5, 2'b10, 5'd3, "add");
    expect_res(32'd12);
    step();
    one(OP_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, "sra");
    one(OP_SLTU,  32'd1,         32'hFFFF_FFFF, 32'd1,         "sltu");
    one(OP_SUB,   32'd3,         32'd5,         32'hFFFF_FFFE, "sub");
    one(OP_SLL,   32'd1,         32'h0000_003F, 32'h8000_0000, "sll");
    one(OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         "slt");
    one(OP_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, "srl");
    one(OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, "xor");
    one(OP_OR,    32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, "or");
    one(OP_AND,   32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, "and");
    one(OP_PASSB, 32'd123,       32'hABCD_E000, 32'hABCD_E000, "passb");
    one(5'd25,    32'd1,         32'd2,         32'd0,         "code25");
    one(OP_ADD,   32'hFFFF_FFFF, 32'd1,         32'd0,         "add_wrap");

    prev_pc = cur.pc;
    drive(OP_ADD, 32'd10, 32'd20, 2'b01, 5'd4, "add_after_keep");
    expect_res(32'd30);
    keep = 1'b1;
    repeat (2) step();
    chk("keep_hold", {ALU_co_pype, PCp4_pype2}, {32'd0, prev_pc});
    keep = 1'b0;
    step();

    drive(OP_ADD, 32'd1, 32'd1, 2'b10, 5'd2, "flushed");
    nop = 1'b1;
    step();
    nop = 1'b0;
    idle_in();
    #1;
    chk_zero("nop_bubble");

`ifdef RV32M_EN
    one(OP_MUL,    32'd6,         32'd7,         32'd42,        "mul");
    one(OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         "mulh_m1");
    one(OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min");
    one(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu");
    one(OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu");

    div_run(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2", -1);
    div_run(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2", -1);
    div_run(OP_DIVU, 32'd100, 32'd7, 32'd14, "divu", -1);
    div_run(OP_REMU, 32'd100, 32'd7, 32'd2,  "remu", -1);
    div_run(OP_DIV,  32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2", -1);
    div_run(OP_REM,  32'd7, 32'hFFFF_FFFE, 32'd1, "rem_7_m2", -1);
    div_run(OP_DIV,  32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2,
            "div_keep", 6);

    spec_one(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_by0");
    spec_one(OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF, "div_by0");
    spec_one(OP_REM,  32'd9, 32'd0, 32'd9, "rem_by0");
    spec_one(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
             "div_ovf");
    spec_one(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, "rem_ovf");

    drive(OP_DIV, 32'd1000, 32'd3, 2'b00, 5'd6, "div_nop");
    repeat (5) step();
    chk("div_nop_busy", 128'(ex_busy), 128'd1);
    nop = 1'b1;
    step();
    nop = 1'b0;
    idle_in();
    #1;
    chk_zero("nop_abort");
    one(OP_ADD, 32'd2, 32'd3, 32'd5, "add_after_nop");

    drive(OP_DIV, 32'd1000, 32'd3, 2'b00, 5'd6, "div_rst");
    repeat (6) step();
    rst = 1'b1;
    drive(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 5'd8,
          "mulhu_after_rst");
    step();
    chk_zero("rst_abort");
    rst = 1'b0;
    expect_res(32'hFFFF_FFFE);
    step();
`else
    one(OP_MUL, 32'd6, 32'd7, 32'd0, "mul_off");
    spec_one(OP_DIV, 32'd5, 32'd0, 32'd0, "div_off");
    spec_one(OP_DIVU, 32'd100, 32'd7, 32'd0, "divu_off");
`endif

    idle_in();
    repeat (3) step();
    chk("scoreboard_drained", 128'(sbq.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
